// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: frame sequencer for the 2x2 median filter (intake, line buffer, window strobes, drain, done)
module median_frame_ctrl #(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720,
  parameter int PIPE_LAT     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            out_ready_i,
  output logic                            out_valid_o,
  output logic [$clog2(IMAGE_LEN)-1:0]    lb_addr_o,
  output logic                            lb_en_o,
  output logic                            win_shift_o,
  output logic                            win_valid_o,
  output logic [$clog2(IMAGE_LEN)-1:0]    x_o,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] y_o,
  output logic                            busy_o,
  output logic                            done_o
);
  localparam int XW = $clog2(IMAGE_LEN);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int N  = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
  localparam int NW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t              state;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [NW-1:0]       out_cnt;
  logic [PIPE_LAT-1:0] vpipe;
  logic                pipe_en, accept, x_last, y_last, out_hs;
  assign out_valid_o = vpipe[PIPE_LAT-1];
  assign pipe_en     = out_ready_i | ~out_valid_o;
  assign in_ready_o  = (state == RUN) & pipe_en;
  assign accept      = in_valid_i & in_ready_o;
  assign x_last      = x == XW'(IMAGE_LEN - 1);
  assign y_last      = y == YW'(IMAGE_HEIGHT - 1);
  assign out_hs      = out_valid_o & out_ready_i;
  assign lb_en_o     = accept;
  assign lb_addr_o   = x;
  assign win_shift_o = (state == DRAIN) ? pipe_en : accept;
  // row 0 / column 0 only prime the line buffer and window registers
  assign win_valid_o = accept & (x != '0) & (y != '0);
  assign x_o         = x;
  assign y_o         = y;
  assign busy_o      = state != IDLE;
  assign done_o      = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      out_cnt <= '0;
      vpipe   <= '0;
    end else begin
      if (win_shift_o) vpipe <= (vpipe << 1) | PIPE_LAT'(win_valid_o);
      if (out_hs) out_cnt <= out_cnt + 1'b1;
      if (accept) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
      end
      case (state)
        IDLE: if (start_i) begin
          state   <= RUN;
          x       <= '0;
          y       <= '0;
          out_cnt <= '0;
          vpipe   <= '0;
        end
        RUN:   if (accept & x_last & y_last) state <= DRAIN;
        DRAIN: if (out_hs && out_cnt == NW'(N - 1)) state <= DONE;
        DONE:  state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: scoreboard bench for the median filter frame sequencer on a 4x3 frame
module tb_median_frame_ctrl;
  localparam int L = 4, H = 3, P = 2, N = (L - 1) * (H - 1);
  logic clk = 0, rst = 1, start_i = 0, in_valid_i = 0, out_ready_i = 1;
  logic in_ready_o, out_valid_o, lb_en_o, win_shift_o, win_valid_o, busy_o, done_o;
  logic [1:0] lb_addr_o, x_o, y_o;
  int vec = 0, bad = 0;
  int mx, my, hs_cnt, win_cnt, done_cnt;
  bit mrun, mbusy, done_pend, prev_stall;
  int q[$];

  median_frame_ctrl #(.IMAGE_LEN(L), .IMAGE_HEIGHT(H), .PIPE_LAT(P)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_ready_i(out_ready_i), .out_valid_o(out_valid_o), .lb_addr_o(lb_addr_o), .lb_en_o(lb_en_o),
    .win_shift_o(win_shift_o), .win_valid_o(win_valid_o), .x_o(x_o), .y_o(y_o),
    .busy_o(busy_o), .done_o(done_o));

  always #5 clk = ~clk;

  task automatic cycle();
    bit er, acc, es, hs;
    @(negedge clk);
    er = mrun && (out_ready_i || !out_valid_o);
    acc = in_valid_i && er;
    es = mrun ? acc : (mbusy && !done_pend) ? (out_ready_i || !out_valid_o) : 1'b0;
    vec++; if (x_o !== 2'(mx)) begin bad++; $display("FAIL x_o got %0d exp %0d", x_o, mx); end
    vec++; if (y_o !== 2'(my)) begin bad++; $display("FAIL y_o got %0d exp %0d", y_o, my); end
    vec++; if (in_ready_o !== er) begin bad++; $display("FAIL in_ready got %b exp %b", in_ready_o, er); end
    vec++; if (lb_en_o !== acc) begin bad++; $display("FAIL lb_en got %b exp %b", lb_en_o, acc); end
    if (acc) begin
      vec++; if (lb_addr_o !== 2'(mx)) begin bad++; $display("FAIL lb_addr got %0d exp %0d", lb_addr_o, mx); end
    end
    vec++; if (win_valid_o !== (acc && mx >= 1 && my >= 1)) begin bad++; $display("FAIL win_valid got %b at x=%0d y=%0d", win_valid_o, mx, my); end
    vec++; if (win_shift_o !== es) begin bad++; $display("FAIL win_shift got %b exp %b", win_shift_o, es); end
    vec++; if (busy_o !== mbusy) begin bad++; $display("FAIL busy got %b exp %b", busy_o, mbusy); end
    vec++; if (done_o !== done_pend) begin bad++; $display("FAIL done got %b exp %b", done_o, done_pend); end
    if (prev_stall) begin
      vec++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stall_hold out_valid got %b exp 1", out_valid_o); end
    end
    if (!mbusy) begin
      vec++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL idle out_valid got %b exp 0", out_valid_o); end
    end
    if (acc && mx >= 1 && my >= 1) begin q.push_back(my * L + mx); win_cnt++; end
    hs = out_valid_o && out_ready_i;
    if (hs) begin
      vec++;
      if (q.size() == 0) begin bad++; $display("FAIL unexpected output got hs exp none"); end
      else void'(q.pop_front());
      hs_cnt++;
    end
    prev_stall = out_valid_o && !out_ready_i;
    if (start_i && !mbusy) begin
      mbusy = 1; mrun = 1; mx = 0; my = 0; hs_cnt = 0; win_cnt = 0; q.delete(); prev_stall = 0;
    end
    if (done_pend) begin done_pend = 0; mbusy = 0; done_cnt++; end
    else if (hs && hs_cnt == N && mbusy && !mrun) done_pend = 1;
    if (acc) begin
      if (mx == L - 1) begin
        mx = 0;
        if (my == H - 1) begin my = 0; mrun = 0; end else my++;
      end else mx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input bit with_start);
    rst = 1; start_i = with_start; in_valid_i = 1;
    @(posedge clk); #1;
    rst = 0; start_i = 0; in_valid_i = 0;
    mx = 0; my = 0; mrun = 0; mbusy = 0; done_pend = 0; hs_cnt = 0; win_cnt = 0; prev_stall = 0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset(1);
    vec++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset busy got %b exp 0", busy_o); end
    vec++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset out_valid got %b exp 0", out_valid_o); end
    vec++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset done got %b exp 0", done_o); end
    vec++; if ({x_o, y_o} !== 4'b0) begin bad++; $display("FAIL reset xy got %0d,%0d exp 0,0", x_o, y_o); end
    vec++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL reset in_ready got %b exp 0", in_ready_o); end
    cycle();
  endtask

  task automatic test_no_start();
    in_valid_i = 1; out_ready_i = 1;
    for (int i = 0; i < 4; i++) cycle();
    vec++; if ({x_o, y_o, lb_en_o} !== 5'b0) begin bad++; $display("FAIL no_start got x=%0d y=%0d en=%b exp 0", x_o, y_o, lb_en_o); end
    in_valid_i = 0;
  endtask

  task automatic test_frame(input bit toggle, input bit poke);
    int c0, i;
    c0 = done_cnt;
    start_i = 1; cycle();
    start_i = 0; in_valid_i = 1;
    for (i = 0; i < 200; i++) begin
      out_ready_i = toggle ? (i % 2 == 0) : 1'b1;
      start_i = poke && (i == 3 || (mbusy && !mrun && !done_pend));
      cycle();
      if (done_cnt != c0) break;
    end
    start_i = 0; in_valid_i = 0; out_ready_i = 1;
    cycle();
    vec++; if (i >= 200) begin bad++; $display("FAIL frame_timeout got %0d cycles exp <200", i); end
    vec++; if (hs_cnt != N) begin bad++; $display("FAIL frame_outputs got %0d exp %0d", hs_cnt, N); end
    vec++; if (win_cnt != N) begin bad++; $display("FAIL frame_windows got %0d exp %0d", win_cnt, N); end
    vec++; if (done_cnt - c0 != 1) begin bad++; $display("FAIL frame_done_count got %0d exp 1", done_cnt - c0); end
    vec++; if (q.size() != 0) begin bad++; $display("FAIL frame_pending got %0d exp 0", q.size()); end
  endtask

  task automatic test_wrap_and_reset();
    int c0;
    c0 = done_cnt;
    out_ready_i = 1;
    start_i = 1; cycle();
    start_i = 0; in_valid_i = 1;
    for (int i = 0; i < 4; i++) cycle();
    vec++; if (x_o !== 2'd0 || y_o !== 2'd1) begin bad++; $display("FAIL wrap got x=%0d y=%0d exp 0,1", x_o, y_o); end
    for (int i = 0; i < 3; i++) cycle();
    do_reset(0);
    vec++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midreset busy got %b exp 0", busy_o); end
    vec++; if ({x_o, y_o} !== 4'b0) begin bad++; $display("FAIL midreset xy got %0d,%0d exp 0,0", x_o, y_o); end
    vec++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL midreset out_valid got %b exp 0", out_valid_o); end
    for (int i = 0; i < 4; i++) cycle();
    vec++; if (done_cnt != c0) begin bad++; $display("FAIL midreset done got %0d pulses exp 0", done_cnt - c0); end
    test_frame(0, 0);
  endtask

  initial begin
    done_cnt = 0;
    test_reset();
    test_no_start();
    test_frame(0, 0);
    test_frame(1, 0);
    test_wrap_and_reset();
    test_frame(0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
